// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter
// Shares one OBI-style slave port between NUM_MASTERS masters. The arbiter
// selects a master either round-robin or by fixed priority. It holds the
// selection stable while the slave stalls the address phase, and it routes
// each in-order response back to the master that issued the request.
module obi_rr_arbiter #(
    parameter int NUM_MASTERS     = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_MASTERS-1:0]                 m_req_i,
    output logic [NUM_MASTERS-1:0]                 m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
    output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  m_rdata_o,
    output logic                                   s_req_o,
    input  logic                                   s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  s_addr_o,
    output logic                                   s_we_o,
    output logic [DATA_WIDTH/8-1:0]                s_be_o,
    output logic [DATA_WIDTH-1:0]                  s_wdata_o,
    input  logic                                   s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
    output logic                                   err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W:0]   NUM_EXT   = (IDX_W + 1)'(NUM_MASTERS);

    logic [IDX_W-1:0] ptr;
    logic             hold;
    logic [IDX_W-1:0] hold_idx;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   rot;
    logic             found;

    logic [IDX_W-1:0] route_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic any_req;
    logic can_issue;
    logic push;
    logic pop;

    assign any_req   = |m_req_i;
    assign can_issue = (count < MAX_CNT) || s_rvalid_i;
    assign s_req_o   = (any_req || hold) && can_issue;
    assign push      = s_req_o && s_gnt_i;
    assign pop       = s_rvalid_i && (count != '0);
    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    // Pick the master to present: a stalled request wins, otherwise round-robin from ptr or lowest index.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        rot   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ARB_MODE == 0) begin
                rot = {1'b0, ptr} + (IDX_W + 1)'(i);
                if (rot >= NUM_EXT) begin
                    rot = rot - NUM_EXT;
                end
                cand = rot[IDX_W-1:0];
            end else begin
                cand = IDX_W'(i);
            end
            if (!found && m_req_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        if (hold) begin
            sel = hold_idx;
        end
    end

    // Mux the selected payload to the slave, and decode the grant and response route to one-hot.
    always_comb begin
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (sel == IDX_W'(k)) begin
                s_addr_o   = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o     = m_we_i[k];
                s_be_o     = m_be_i[k*BE_W +: BE_W];
                s_wdata_o  = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                m_gnt_o[k] = push;
            end
            if (route_mem[head] == IDX_W'(k)) begin
                m_rvalid_o[k] = pop;
            end
        end
    end

    // Advance the round-robin pointer on each handshake, and latch the selection while the slave stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr      <= '0;
            hold     <= 1'b0;
            hold_idx <= '0;
        end else begin
            if (push) begin
                hold <= 1'b0;
                if (ARB_MODE == 0) begin
                    ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                end
            end else if (s_req_o) begin
                hold     <= 1'b1;
                hold_idx <= sel;
            end
        end
    end

    // In-order route FIFO: a handshake records who asked, and a response pops who gets it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int j = 0; j < MAX_OUTSTANDING; j++) begin
                route_mem[j] <= '0;
            end
        end else begin
            if (push) begin
                route_mem[tail] <= sel;
                tail            <= (tail == LAST_SLOT) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST_SLOT) ? '0 : head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error when a response arrives that nobody is waiting for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (s_rvalid_i && (count == '0) && !push) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter
// Drives a round-robin instance (MAX_OUTSTANDING=2) and a fixed-priority instance
// (MAX_OUTSTANDING=3) from shared stimulus. Directed scenarios and a randomized
// run are compared against a queue-based reference model.
module tb_obi_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_we;
    logic [N*BW-1:0] m_be;
    logic [N*DW-1:0] m_wdata;
    logic            s_gnt;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;

    logic [N-1:0]  rr_gnt, rr_rvalid, fp_gnt, fp_rvalid;
    logic [DW-1:0] rr_rdata, fp_rdata, rr_swdata, fp_swdata;
    logic [AW-1:0] rr_saddr, fp_saddr;
    logic [BW-1:0] rr_sbe, fp_sbe;
    logic          rr_sreq, fp_sreq, rr_swe, fp_swe, rr_err, fp_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(2), .ARB_MODE(0)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_gnt_o(rr_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(rr_rvalid), .m_rdata_o(rr_rdata),
        .s_req_o(rr_sreq), .s_gnt_i(s_gnt), .s_addr_o(rr_saddr), .s_we_o(rr_swe),
        .s_be_o(rr_sbe), .s_wdata_o(rr_swdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .err_o(rr_err)
    );

    obi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(3), .ARB_MODE(1)) u_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_gnt_o(fp_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(fp_rvalid), .m_rdata_o(fp_rdata),
        .s_req_o(fp_sreq), .s_gnt_i(s_gnt), .s_addr_o(fp_saddr), .s_we_o(fp_swe),
        .s_be_o(fp_sbe), .s_wdata_o(fp_swdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .err_o(fp_err)
    );

    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_payload;
        m_addr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        m_wdata = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        m_we    = 3'b010;
        m_be    = {4'hF, 4'h3, 4'h1};
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        set_payload();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'h1234_5678;
        set_payload();
        settle();
        checks++; if (rr_rvalid !== 3'b000) begin fails++; $display("[TB] FAIL reset_rvalid got %b want 000", rr_rvalid); end
        checks++; if (fp_rvalid !== 3'b000) begin fails++; $display("[TB] FAIL reset_fp_rvalid got %b want 000", fp_rvalid); end
        checks++; if (rr_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %b want 0", rr_err); end
        checks++; if (rr_sreq !== 1'b0) begin fails++; $display("[TB] FAIL reset_sreq_idle got %b want 0", rr_sreq); end
        m_req = 3'b100;
        s_gnt = 1'b1;
        settle();
        checks++; if (rr_sreq !== 1'b1) begin fails++; $display("[TB] FAIL reset_sreq_comb got %b want 1", rr_sreq); end
        checks++; if (rr_gnt !== 3'b100) begin fails++; $display("[TB] FAIL reset_gnt_comb got %b want 100", rr_gnt); end
        next_cycle();
        checks++; if (rr_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err_held got %b want 0", rr_err); end
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_rr_fairness;
        int order [6] = '{0, 1, 2, 0, 1, 2};
        int prev = -1;
        logic [N-1:0] exp_g, exp_v;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            m_req    = (c < 6) ? 3'b111 : 3'b000;
            s_gnt    = 1'b1;
            s_rvalid = (prev >= 0);
            s_rdata  = 32'hD0 + 32'(c);
            settle();
            exp_g = (c < 6) ? 3'(1 << order[c]) : 3'b000;
            exp_v = (prev >= 0) ? 3'(1 << prev) : 3'b000;
            checks++; if (rr_gnt !== exp_g) begin fails++; $display("[TB] FAIL rr_order c=%0d got %b want %b", c, rr_gnt, exp_g); end
            checks++; if (rr_rvalid !== exp_v) begin fails++; $display("[TB] FAIL rr_rvalid c=%0d got %b want %b", c, rr_rvalid, exp_v); end
            if (prev >= 0) begin
                checks++; if (rr_rdata !== 32'hD0 + 32'(c)) begin fails++; $display("[TB] FAIL rr_rdata c=%0d got %h want %h", c, rr_rdata, 32'hD0 + 32'(c)); end
            end
            if (c < 6) begin
                checks++; if (rr_saddr !== 32'h1000 * 32'(order[c] + 1)) begin fails++; $display("[TB] FAIL rr_addr c=%0d got %h want %h", c, rr_saddr, 32'h1000 * 32'(order[c] + 1)); end
            end
            prev = (c < 6) ? order[c] : -1;
            next_cycle();
        end
        s_rvalid = 1'b0;
    endtask

    task automatic test_fixed_priority;
        do_reset();
        m_req = 3'b110; s_gnt = 1'b1; s_rvalid = 1'b0;
        settle();
        checks++; if (fp_gnt !== 3'b010) begin fails++; $display("[TB] FAIL fp_idle0 got %b want 010", fp_gnt); end
        checks++; if (fp_saddr !== 32'h2000) begin fails++; $display("[TB] FAIL fp_addr got %h want 2000", fp_saddr); end
        next_cycle();
        m_req = 3'b111; s_rvalid = 1'b1; s_rdata = 32'h55;
        settle();
        checks++; if (fp_gnt !== 3'b001) begin fails++; $display("[TB] FAIL fp_win0 got %b want 001", fp_gnt); end
        checks++; if (fp_rvalid !== 3'b010) begin fails++; $display("[TB] FAIL fp_rvalid1 got %b want 010", fp_rvalid); end
        next_cycle();
        settle();
        checks++; if (fp_gnt !== 3'b001) begin fails++; $display("[TB] FAIL fp_win0_again got %b want 001", fp_gnt); end
        checks++; if (fp_rvalid !== 3'b001) begin fails++; $display("[TB] FAIL fp_rvalid2 got %b want 001", fp_rvalid); end
        next_cycle();
        m_req = '0; s_gnt = 1'b0;
        settle();
        checks++; if (fp_rvalid !== 3'b001) begin fails++; $display("[TB] FAIL fp_rvalid3 got %b want 001", fp_rvalid); end
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    task automatic test_hold;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            m_req = (c == 0) ? 3'b100 : 3'b101;
            s_gnt = 1'b0;
            settle();
            checks++; if (rr_sreq !== 1'b1) begin fails++; $display("[TB] FAIL hold_sreq c=%0d got %b want 1", c, rr_sreq); end
            checks++; if (rr_saddr !== 32'h3000) begin fails++; $display("[TB] FAIL hold_addr c=%0d got %h want 3000", c, rr_saddr); end
            checks++; if (rr_gnt !== 3'b000) begin fails++; $display("[TB] FAIL hold_gnt c=%0d got %b want 000", c, rr_gnt); end
            next_cycle();
        end
        m_req = 3'b101; s_gnt = 1'b1;
        settle();
        checks++; if (rr_gnt !== 3'b100) begin fails++; $display("[TB] FAIL hold_release got %b want 100", rr_gnt); end
        checks++; if (rr_saddr !== 32'h3000) begin fails++; $display("[TB] FAIL hold_release_addr got %h want 3000", rr_saddr); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'h77;
        settle();
        checks++; if (rr_gnt !== 3'b001) begin fails++; $display("[TB] FAIL hold_next got %b want 001", rr_gnt); end
        checks++; if (rr_rvalid !== 3'b100) begin fails++; $display("[TB] FAIL hold_rvalid got %b want 100", rr_rvalid); end
        next_cycle();
        m_req = '0; s_gnt = 1'b0;
        settle();
        checks++; if (rr_rvalid !== 3'b001) begin fails++; $display("[TB] FAIL hold_drain got %b want 001", rr_rvalid); end
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    task automatic test_outstanding;
        do_reset();
        m_req = 3'b001; s_gnt = 1'b1; s_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++; if (rr_gnt !== 3'b001) begin fails++; $display("[TB] FAIL lim_grant c=%0d got %b want 001", c, rr_gnt); end
            next_cycle();
        end
        settle();
        checks++; if (rr_sreq !== 1'b0) begin fails++; $display("[TB] FAIL lim_full_sreq got %b want 0", rr_sreq); end
        checks++; if (rr_gnt !== 3'b000) begin fails++; $display("[TB] FAIL lim_full_gnt got %b want 000", rr_gnt); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'hAB;
        settle();
        checks++; if (rr_sreq !== 1'b1) begin fails++; $display("[TB] FAIL lim_pop_sreq got %b want 1", rr_sreq); end
        checks++; if (rr_gnt !== 3'b001) begin fails++; $display("[TB] FAIL lim_pop_gnt got %b want 001", rr_gnt); end
        checks++; if (rr_rvalid !== 3'b001) begin fails++; $display("[TB] FAIL lim_pop_rvalid got %b want 001", rr_rvalid); end
        next_cycle();
        s_rvalid = 1'b0;
        settle();
        checks++; if (rr_sreq !== 1'b0) begin fails++; $display("[TB] FAIL lim_still_full got %b want 0", rr_sreq); end
        next_cycle();
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++; if (rr_rvalid !== 3'b001) begin fails++; $display("[TB] FAIL lim_drain c=%0d got %b want 001", c, rr_rvalid); end
            next_cycle();
        end
        s_rvalid = 1'b0;
        settle();
        checks++; if (rr_err !== 1'b0) begin fails++; $display("[TB] FAIL lim_err got %b want 0", rr_err); end
    endtask

    task automatic test_route_mix;
        logic [N-1:0] reqs [3] = '{3'b100, 3'b001, 3'b010};
        logic [DW-1:0] data [3] = '{32'hA, 32'hB, 32'hC};
        do_reset();
        s_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            m_req = reqs[c];
            settle();
            checks++; if (fp_gnt !== reqs[c]) begin fails++; $display("[TB] FAIL mix_grant c=%0d got %b want %b", c, fp_gnt, reqs[c]); end
            next_cycle();
        end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_rdata = data[c];
            settle();
            checks++; if (fp_rvalid !== reqs[c]) begin fails++; $display("[TB] FAIL mix_rvalid c=%0d got %b want %b", c, fp_rvalid, reqs[c]); end
            checks++; if (fp_rdata !== data[c]) begin fails++; $display("[TB] FAIL mix_rdata c=%0d got %h want %h", c, fp_rdata, data[c]); end
            next_cycle();
        end
        s_rvalid = 1'b0;
        settle();
        checks++; if (fp_err !== 1'b0) begin fails++; $display("[TB] FAIL mix_err got %b want 0", fp_err); end
    endtask

    task automatic test_error_reset;
        do_reset();
        s_rvalid = 1'b1; s_rdata = 32'hEE;
        settle();
        checks++; if (rr_rvalid !== 3'b000) begin fails++; $display("[TB] FAIL err_no_rvalid got %b want 000", rr_rvalid); end
        checks++; if (rr_err !== 1'b0) begin fails++; $display("[TB] FAIL err_before got %b want 0", rr_err); end
        next_cycle();
        s_rvalid = 1'b0;
        settle();
        checks++; if (rr_err !== 1'b1) begin fails++; $display("[TB] FAIL err_set got %b want 1", rr_err); end
        m_req = 3'b001; s_gnt = 1'b1;
        settle();
        checks++; if (rr_gnt !== 3'b001) begin fails++; $display("[TB] FAIL err_grant got %b want 001", rr_gnt); end
        next_cycle();
        m_req = '0; s_gnt = 1'b0;
        settle();
        rst_n = 1'b0;
        settle();
        checks++; if (rr_err !== 1'b0) begin fails++; $display("[TB] FAIL err_async_clear got %b want 0", rr_err); end
        next_cycle();
        rst_n = 1'b1;
        s_rvalid = 1'b1;
        settle();
        checks++; if (rr_rvalid !== 3'b000) begin fails++; $display("[TB] FAIL err_route_discard got %b want 000", rr_rvalid); end
        next_cycle();
        s_rvalid = 1'b0;
        settle();
        checks++; if (rr_err !== 1'b1) begin fails++; $display("[TB] FAIL err_stale_resp got %b want 1", rr_err); end
        m_req = 3'b111; s_gnt = 1'b1;
        settle();
        checks++; if (rr_gnt !== 3'b001) begin fails++; $display("[TB] FAIL err_ptr_reset got %b want 001", rr_gnt); end
        next_cycle();
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        settle();
        checks++; if (rr_rvalid !== 3'b001) begin fails++; $display("[TB] FAIL err_drain got %b want 001", rr_rvalid); end
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    task automatic test_random;
        int rr_ptr = 0;
        int held = -1;
        int route_q [$];
        bit m_err = 1'b0;
        int sel;
        bit exp_sreq, hs;
        logic [N-1:0] exp_g, exp_v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            m_req = 3'($urandom_range(0, 7));
            if (held >= 0) m_req[held] = 1'b1;
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (route_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            s_rdata  = $urandom();
            m_addr   = {$urandom(), $urandom(), $urandom()};
            m_wdata  = {$urandom(), $urandom(), $urandom()};
            m_we     = 3'($urandom_range(0, 7));
            m_be     = 12'($urandom());

            sel = 0;
            if (held >= 0) begin
                sel = held;
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (m_req[(rr_ptr + k) % N]) sel = (rr_ptr + k) % N;
                end
            end
            exp_sreq = ((m_req != 0) || (held >= 0)) && ((route_q.size() < 2) || s_rvalid);
            hs       = exp_sreq && s_gnt;
            exp_g    = hs ? 3'(1 << sel) : 3'b000;
            exp_v    = (s_rvalid && route_q.size() > 0) ? 3'(1 << route_q[0]) : 3'b000;

            settle();
            checks++; if (rr_sreq !== exp_sreq) begin fails++; $display("[TB] FAIL rnd_sreq c=%0d got %b want %b", c, rr_sreq, exp_sreq); end
            checks++; if (rr_gnt !== exp_g) begin fails++; $display("[TB] FAIL rnd_gnt c=%0d got %b want %b", c, rr_gnt, exp_g); end
            checks++; if (rr_rvalid !== exp_v) begin fails++; $display("[TB] FAIL rnd_rvalid c=%0d got %b want %b", c, rr_rvalid, exp_v); end
            checks++; if (rr_err !== m_err) begin fails++; $display("[TB] FAIL rnd_err c=%0d got %b want %b", c, rr_err, m_err); end
            if (exp_v != 0) begin
                checks++; if (rr_rdata !== s_rdata) begin fails++; $display("[TB] FAIL rnd_rdata c=%0d got %h want %h", c, rr_rdata, s_rdata); end
            end
            if (exp_sreq) begin
                checks++; if (rr_saddr !== m_addr[sel*AW +: AW]) begin fails++; $display("[TB] FAIL rnd_addr c=%0d got %h want %h", c, rr_saddr, m_addr[sel*AW +: AW]); end
                checks++; if (rr_swe !== m_we[sel]) begin fails++; $display("[TB] FAIL rnd_we c=%0d got %b want %b", c, rr_swe, m_we[sel]); end
                checks++; if (rr_sbe !== m_be[sel*BW +: BW]) begin fails++; $display("[TB] FAIL rnd_be c=%0d got %h want %h", c, rr_sbe, m_be[sel*BW +: BW]); end
                checks++; if (rr_swdata !== m_wdata[sel*DW +: DW]) begin fails++; $display("[TB] FAIL rnd_wdata c=%0d got %h want %h", c, rr_swdata, m_wdata[sel*DW +: DW]); end
            end

            if (s_rvalid && route_q.size() > 0) begin
                void'(route_q.pop_front());
            end else if (s_rvalid && !hs) begin
                m_err = 1'b1;
            end
            if (hs) begin
                route_q.push_back(sel);
                rr_ptr = (sel + 1) % N;
                held   = -1;
            end else if (exp_sreq) begin
                held = sel;
            end
            next_cycle();
        end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    endtask

    initial begin
        $display("[TB] starting obi_rr_arbiter bench");
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_hold();
        test_outstanding();
        test_route_mix();
        test_error_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
